// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection, PC register, IRQ sync/pending latch,
// kernel-mode jr protection, EPC capture and retired-instruction counter.
module pc_sequencer #(
    parameter int unsigned   AW    = 32,
    parameter logic [AW-1:0] START = 32'h0000_0000,
    parameter logic [AW-1:0] ILLOP = 32'h8000_0004,
    parameter logic [AW-1:0] XADR  = 32'h8000_0008,
    parameter int unsigned   SYNC  = 2,
    parameter int unsigned   CW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic [2:0]    pc_src,
    input  logic          cond,
    input  logic [15:0]   imm,
    input  logic [25:0]   jt,
    input  logic [AW-1:0] jr_target,
    input  logic          irq_in,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    output logic          kernel,
    output logic          irq_ack,
    output logic [AW-1:0] epc,
    output logic [CW-1:0] instret
);

    // Fewer than two synchroniser flops is not metastability-safe.
    localparam int unsigned SD = (SYNC < 2) ? 2 : SYNC;

    logic [SD-1:0] sync_q, sync_d;
    logic          lvl_q, lvl_d;
    logic          pending_q, pending_d;
    logic          irq_ack_q, irq_ack_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] epc_q, epc_d;
    logic [CW-1:0] instret_q, instret_d;

    logic          irq_edge;
    logic          take;
    logic [AW-1:0] imm_off;
    logic [AW-2:0] seq_low;
    logic [AW-2:0] br_low;
    logic [AW-1:0] seq_pc;
    logic [AW-1:0] br_pc;
    logic [AW-1:0] jmp_pc;
    logic [AW-1:0] jr_pc;
    logic [AW-1:0] sel_pc;

    assign pc       = pc_q;
    assign pc_plus4 = seq_pc;
    assign kernel   = pc_q[AW-1];
    assign irq_ack  = irq_ack_q;
    assign epc      = epc_q;
    assign instret  = instret_q;

    // Address arithmetic: the low AW-1 bits wrap, the kernel bit is kept.
    always_comb begin
        imm_off  = {{(AW-18){imm[15]}}, imm, 2'b00};
        seq_low  = pc_q[AW-2:0] + (AW-1)'(4);
        br_low   = seq_low + imm_off[AW-2:0];
        seq_pc   = {pc_q[AW-1], seq_low};
        br_pc    = {pc_q[AW-1], br_low};
        jmp_pc   = {pc_q[AW-1:28], jt, 2'b00};
        jr_pc    = {jr_target[AW-1] & pc_q[AW-1],
                    jr_target[AW-2:0]};
    end

    // Next-PC mux driven by the control unit's pc_src.
    always_comb begin
        sel_pc = seq_pc;
        unique case (pc_src)
            3'b000: sel_pc = seq_pc;
            3'b001: sel_pc = cond ? br_pc : seq_pc;
            3'b010: sel_pc = jmp_pc;
            3'b011: sel_pc = jr_pc;
            3'b100: sel_pc = ILLOP;
            3'b101: sel_pc = XADR;
            3'b110,
            3'b111: sel_pc = START;
            default: sel_pc = START;
        endcase
    end

    // IRQ edge detect on the synchronised level; take only from user mode.
    always_comb begin
        sync_d   = {sync_q[SD-2:0], irq_in};
        lvl_d    = sync_q[SD-1];
        irq_edge = sync_q[SD-1] & ~lvl_q;
        take     = advance & pending_q & ~pc_q[AW-1];
    end

    // State update: IRQ take overrides pc_src; a stall freezes everything.
    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        instret_d = instret_q;
        irq_ack_d = 1'b0;
        pending_d = pending_q | irq_edge;
        unique case (1'b1)
            take: begin
                pc_d      = ILLOP;
                epc_d     = pc_q;
                irq_ack_d = 1'b1;
                pending_d = irq_edge;
            end
            advance & ~take: begin
                pc_d = sel_pc;
            end
            default: ;
        endcase
        if (advance) begin
            instret_d = instret_q + CW'(1);
        end
    end

    // Registers, asynchronously cleared by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            lvl_q     <= 1'b0;
            pending_q <= 1'b0;
            irq_ack_q <= 1'b0;
            pc_q      <= START;
            epc_q     <= '0;
            instret_q <= '0;
        end else begin
            sync_q    <= sync_d;
            lvl_q     <= lvl_d;
            pending_q <= pending_d;
            irq_ack_q <= irq_ack_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer with
// hand-computed expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance;
    logic [2:0]  pc_src;
    logic        cond;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] jr_target;
    logic        irq_in;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        kernel;
    logic        irq_ack;
    logic [31:0] epc;
    logic [31:0] instret;

    int errs   = 0;
    int checks = 0;
    int n_adv  = 0;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .pc_src    (pc_src),
        .cond      (cond),
        .imm       (imm),
        .jt        (jt),
        .jr_target (jr_target),
        .irq_in    (irq_in),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .kernel    (kernel),
        .irq_ack   (irq_ack),
        .epc       (epc),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (advance && reset) n_adv++;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        advance   = 1'b0;
        pc_src    = 3'b000;
        cond      = 1'b0;
        imm       = 16'h0;
        jt        = 26'h0;
        jr_target = 32'h0;
        irq_in    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_kernel", 32'(kernel), 32'h0);
        check("rst_ack", 32'(irq_ack), 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_pend", 32'(dut.pending_q), 32'h0);

        reset   = 1'b1;
        advance = 1'b1;
        step(); check("seq1", pc, 32'h4);
        step(); check("seq2", pc, 32'h8);
        step(); check("seq3", pc, 32'hC);
        step(); check("seq4", pc, 32'h10);
        check("seq_instret", instret, 32'd4);

        pc_src = 3'b010; jt = 26'h10;
        step(); check("jmp40", pc, 32'h40);
        pc_src = 3'b001; imm = 16'hFFFE; cond = 1'b1;
        step(); check("br_taken", pc, 32'h3C);
        pc_src = 3'b010;
        step(); check("jmp40b", pc, 32'h40);
        pc_src = 3'b001; cond = 1'b0;
        step(); check("br_not", pc, 32'h44);
        check("pcp4", pc_plus4, 32'h48);

        pc_src = 3'b011; jr_target = 32'h8000_0100;
        step(); check("jr_user", pc, 32'h100);
        check("jr_user_k", 32'(kernel), 32'h0);
        pc_src = 3'b100;
        step(); check("illop", pc, 32'h8000_0004);
        check("illop_k", 32'(kernel), 32'h1);
        check("illop_ack", 32'(irq_ack), 32'h0);
        pc_src = 3'b011;
        step(); check("jr_kern", pc, 32'h8000_0100);
        pc_src = 3'b101;
        step(); check("xadr", pc, 32'h8000_0008);
        pc_src = 3'b110;
        step(); check("start", pc, 32'h0);

        pc_src = 3'b011; jr_target = 32'h20;
        step(); check("to20", pc, 32'h20);
        pc_src = 3'b000; irq_in = 1'b1;
        step(); irq_in = 1'b0;
        check("irq_e1_pc", pc, 32'h24);
        check("irq_e1_ack", 32'(irq_ack), 32'h0);
        step(); check("irq_e2_ack", 32'(irq_ack), 32'h0);
        step(); check("irq_e3_pc", pc, 32'h2C);
        check("irq_e3_pend", 32'(dut.pending_q), 32'h1);
        step(); check("take_pc", pc, 32'h8000_0004);
        check("take_epc", epc, 32'h2C);
        check("take_ack", 32'(irq_ack), 32'h1);
        check("take_pend", 32'(dut.pending_q), 32'h0);
        step(); check("ack_drop", 32'(irq_ack), 32'h0);
        check("after_take", pc, 32'h8000_0008);
        step(); step();
        check("k10", pc, 32'h8000_0010);

        pc_src = 3'b011; jr_target = 32'h8000_0010; irq_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); irq_in = 1'b0;
            check("mask_ack", 32'(irq_ack), 32'h0);
        end
        check("mask_pc", pc, 32'h8000_0010);
        check("mask_pend", 32'(dut.pending_q), 32'h1);
        jr_target = 32'h50;
        step(); check("ret_pc", pc, 32'h50);
        check("ret_k", 32'(kernel), 32'h0);
        check("ret_ack", 32'(irq_ack), 32'h0);
        advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h50);
            check("stall_ack", 32'(irq_ack), 32'h0);
        end
        check("stall_instret", instret, 32'(n_adv));
        advance = 1'b1; pc_src = 3'b010; jt = 26'h0;
        step(); check("take2_pc", pc, 32'h8000_0004);
        check("take2_epc", epc, 32'h50);
        check("take2_ack", 32'(irq_ack), 32'h1);
        check("take2_instret", instret, 32'(n_adv));

        pc_src = 3'b011; jr_target = 32'h8000_0004; irq_in = 1'b1;
        step(); irq_in = 1'b0;
        repeat (3) step();
        check("pre_rst_pend", 32'(dut.pending_q), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_pend", 32'(dut.pending_q), 32'h0);
        check("arst_instret", instret, 32'h0);
        check("arst_epc", epc, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_adv = 0;

        pc_src = 3'b011; jr_target = 32'h7FFF_FFFC;
        step(); check("top_pc", pc, 32'h7FFF_FFFC);
        check("top_pcp4", pc_plus4, 32'h0);
        pc_src = 3'b000;
        step(); check("wrap_pc", pc, 32'h0);
        check("wrap_k", 32'(kernel), 32'h0);
        check("wrap_instret", instret, 32'(n_adv));
        pc_src = 3'b100;
        step();
        pc_src = 3'b011; jr_target = 32'hFFFF_FFFC;
        step(); check("ktop_pc", pc, 32'hFFFF_FFFC);
        pc_src = 3'b000;
        step(); check("kwrap_pc", pc, 32'h8000_0000);
        check("kwrap_k", 32'(kernel), 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
